// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: reduces a packet of words with OR/AND/XOR/NOR and presents
// one result per packet, cutting packets at MAX_WORDS beats.
module logic_reduce_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [1:0]       OP_OR   = 2'b00;
    localparam logic [1:0]       OP_AND  = 2'b01;
    localparam logic [1:0]       OP_XOR  = 2'b10;
    localparam logic [1:0]       OP_NOR  = 2'b11;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_trunc_q, out_trunc_d;

    logic               accept;
    logic [1:0]         op_sel;
    logic [WIDTH-1:0]   acc_new;
    logic [CNT_W-1:0]   cnt_new;
    logic               term;

    // Ready is a decode of the state so it rises in the same cycle reset releases
    assign in_ready = !reset && (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    // Candidate accumulator/count for the beat currently presented
    always_comb begin
        op_sel  = (state_q == IDLE) ? op : op_q;
        acc_new = in_data;
        cnt_new = CNT_W'(1);
        if (state_q != IDLE) begin
            cnt_new = count_q + CNT_W'(1);
            case (op_q)
                OP_AND:  acc_new = acc_q & in_data;
                OP_XOR:  acc_new = acc_q ^ in_data;
                default: acc_new = acc_q | in_data;
            endcase
        end
        term = in_last || (cnt_new == MAX_CNT);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = acc_new;
                    count_d = cnt_new;
                    op_d    = op_sel;
                    if (term) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = (op_sel == OP_NOR) ? ~acc_new : acc_new;
                        out_count_d = cnt_new;
                        out_trunc_d = !in_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_count_d = '0;
                    out_trunc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            op_q        <= OP_OR;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: doc/logic_reduce_unit.md
LOGIC_REDUCE_UNIT -- requirements
Module: logic_reduce_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter MAX_WORDS, default 8, giving the maximum words per packet (legal range 1..255).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of out_count, sized to hold MAX_WORDS.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port op, input, 2 bits: 00 OR, 01 AND, 10 XOR, 11 NOR; sampled on the first beat of a packet only.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an input word is presented.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: the operand word.
REQ-010 The block SHALL have port in_last, input, 1 bit: marks the final word of a packet.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: the reduction result.
REQ-014 The block SHALL have port out_count, output, CNT_W bits: number of words reduced.
REQ-015 The block SHALL have port out_trunc, output, 1 bit: packet was cut at MAX_WORDS without in_last.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both 1 at a rising clk edge.
REQ-017 The FSM SHALL have states IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-018 An IDLE accept SHALL latch op into op_r, load acc with in_data and set count to 1.
REQ-019 An ACCUM accept SHALL update acc to (acc OR in_data) for OR/NOR, (acc AND in_data) for AND and (acc XOR in_data) for XOR, and SHALL increment count.
REQ-020 Any accept SHALL move the FSM to HOLD when in_last=1 or the new count equals MAX_WORDS; otherwise IDLE SHALL go to ACCUM and ACCUM SHALL remain in ACCUM.
REQ-021 out_trunc SHALL be set on entry to HOLD only if the count reached MAX_WORDS with in_last=0 on that beat.
REQ-022 In HOLD, out_valid SHALL be 1, out_data SHALL equal acc (or ~acc when op_r=NOR) and out_count SHALL equal count.
REQ-023 All outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 HOLD with out_ready=1 SHALL return to IDLE, with out_valid=0 and out_trunc=0 on the next cycle.
REQ-025 The latency SHALL be 1 cycle: out_valid rises the cycle after the terminating beat is accepted.
REQ-026 The minimum spacing between packets SHALL be one bubble cycle (HOLD then IDLE).
REQ-027 With in_valid=0 in ACCUM, the block SHALL hold state indefinitely, with no timeout.
REQ-028 A change on op after the first beat SHALL be ignored until the next packet.
REQ-029 A single-word packet SHALL give out_data=in_data (OR/AND/XOR) or ~in_data (NOR), with out_count=1.
REQ-030 With MAX_WORDS=1, every packet SHALL terminate on its first beat, and out_trunc SHALL equal ~in_last.
REQ-031 There SHALL be no arithmetic carry; count SHALL never exceed MAX_WORDS and SHALL not wrap.

Reset
REQ-032 While reset=1, the block SHALL force state=IDLE, acc=0, count=0, op_r=00, out_valid=0, out_trunc=0, out_data=0, out_count=0 and in_ready=0.
REQ-033 After reset deasserts, in_ready SHALL be 1 in the same cycle; the first accept SHALL occur at the first rising edge after deassertion.
REQ-034 Reset asserted mid-packet or in HOLD SHALL discard the partial or pending result, and no out_valid pulse SHALL follow.

Verification (WIDTH=8, MAX_WORDS=4)
REQ-035 OR packet 0x01,0x02,0x80(last) -> one cycle later out_valid=1, out_data=0x83, out_count=3, out_trunc=0.
REQ-036 NOR packet 0x0F,0x30(last) -> out_data=0xC0; AND packet 0xF0,0x3C(last) -> out_data=0x30.
REQ-037 XOR with 5 words 0x01,0x02,0x04,0x08,0x10 and no last -> first 4 reduce to out_data=0x0F, out_count=4, out_trunc=1; 5th word starts a new packet after out_ready.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_* constant, in_ready=0; release -> out_valid=0 next cycle, in_ready=1.
REQ-039 Change op from XOR to AND after beat 1 of 0xAA,0x0F(last) -> out_data=0xA5.
REQ-040 Assert reset after 2 of 3 beats -> all outputs 0 immediately, no out_valid afterwards; a new packet 0x55(last) -> out_data=0x55, out_count=1.
